// File: rtl/ppc_mem_pkg.sv
// Shared widths, requester identity and FIFO depth default for the memory read arbiter.
package ppc_mem_pkg;

  localparam int AW          = 61;
  localparam int DW          = 64;
  localparam int MAX_OUT_DEF = 4;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // The requester that is not o; used for the round-robin tie break.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_F) ? OWN_D : OWN_F;
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// In-order record of which requester issued each outstanding memory request.
module owner_fifo
  import ppc_mem_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  owner_t                     din_i,
  input  logic                       pop_i,
  output owner_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  owner_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Ignore pushes into a full FIFO and pops from an empty one.
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_ok ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + CW'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Owner storage needs no reset: it is only read while the count says it is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin sharing of one memory read port between fetch and load, with in-order response steering.
module mem_read_arbiter
  import ppc_mem_pkg::*;
#(
  parameter int AW      = ppc_mem_pkg::AW,
  parameter int DW      = ppc_mem_pkg::DW,
  parameter int MAX_OUT = ppc_mem_pkg::MAX_OUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         f_req_valid,
  input  logic [0:AW-1]                f_req_addr,
  output logic                         f_req_ready,
  output logic                         f_rsp_valid,
  output logic [0:DW-1]                f_rsp_data,
  input  logic                         d_req_valid,
  input  logic [0:AW-1]                d_req_addr,
  output logic                         d_req_ready,
  output logic                         d_rsp_valid,
  output logic [0:DW-1]                d_rsp_data,
  output logic                         mem_req_valid,
  output logic [0:AW-1]                mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_rsp_valid,
  input  logic [0:DW-1]                mem_rsp_data,
  output logic [$clog2(MAX_OUT):0]     outstanding,
  output logic                         err_orphan
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  owner_t          last_grant_q, last_grant_d;
  logic            lock_valid_q, lock_valid_d;
  owner_t          lock_owner_q, lock_owner_d;
  logic            err_q, err_d;

  owner_t          sel;
  logic            sel_valid;
  logic            can_issue;
  logic            req_valid;
  logic            hs;
  logic            pop;
  owner_t          head;
  logic [CW-1:0]   count;
  logic            fifo_empty;
  logic            fifo_full;

  // Pick the requester: a stalled request keeps its owner, otherwise round-robin on ties.
  always_comb begin
    sel = OWN_F;
    if (lock_valid_q) sel = lock_owner_q;
    else if (f_req_valid && d_req_valid) sel = other_owner(last_grant_q);
    else if (d_req_valid) sel = OWN_D;
  end

  // Full means count == MAX_OUT, from the registered count only.
  assign can_issue = !fifo_full;
  assign sel_valid = (sel == OWN_D) ? d_req_valid : f_req_valid;
  assign req_valid = rst_n && can_issue && sel_valid;
  assign hs        = req_valid && mem_req_ready;
  assign pop       = mem_rsp_valid && !fifo_empty;

  assign mem_req_valid = req_valid;
  assign mem_req_addr  = !rst_n ? '0 : ((sel == OWN_D) ? d_req_addr : f_req_addr);
  assign f_req_ready   = rst_n && (sel == OWN_F) && mem_req_ready && can_issue;
  assign d_req_ready   = rst_n && (sel == OWN_D) && mem_req_ready && can_issue;

  assign f_rsp_valid   = rst_n && pop && (head == OWN_F);
  assign d_rsp_valid   = rst_n && pop && (head == OWN_D);
  assign f_rsp_data    = rst_n ? mem_rsp_data : '0;
  assign d_rsp_data    = rst_n ? mem_rsp_data : '0;

  assign outstanding   = count;
  assign err_orphan    = err_q;

  owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (hs),
    .din_i   (sel),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Grant history, stall lock and sticky orphan flag next state.
  always_comb begin
    last_grant_d = last_grant_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    err_d        = err_q;
    if (hs) begin
      last_grant_d = sel;
      lock_valid_d = 1'b0;
    end else if (req_valid) begin
      lock_valid_d = 1'b1;
      lock_owner_d = sel;
    end
    if (mem_rsp_valid && fifo_empty) err_d = 1'b1;
  end

  // Control registers; last grant resets to load so fetch wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_D;
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWN_F;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed table, corner sequences, randomized run against a queue model.
module tb_mem_read_arbiter;

  localparam int TAW = 61;
  localparam int TDW = 64;
  localparam int TMO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            f_req_valid, d_req_valid, mem_req_ready, mem_rsp_valid;
  logic [0:TAW-1]  f_req_addr, d_req_addr, mem_req_addr;
  logic            f_req_ready, d_req_ready, f_rsp_valid, d_rsp_valid, mem_req_valid;
  logic [0:TDW-1]  f_rsp_data, d_rsp_data, mem_rsp_data;
  logic [2:0]      outstanding;
  logic            err_orphan;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_read_arbiter #(.AW(TAW), .DW(TDW), .MAX_OUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct {
    logic        fv;  logic [60:0] fa;
    logic        dv;  logic [60:0] da;
    logic        rdy; logic        rv; logic [63:0] rd;
    logic        e_mv; logic [60:0] e_ma;
    logic        e_fr; logic e_dr; logic e_fv; logic e_dv;
    int          e_out;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [60:0] fa, input logic dv, input logic [60:0] da,
                       input logic rdy, input logic rv, input logic [63:0] rd);
    f_req_valid = fv; f_req_addr = fa;
    d_req_valid = dv; d_req_addr = da;
    mem_req_ready = rdy; mem_rsp_valid = rv; mem_rsp_data = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] dfn(input logic [60:0] a);
    return {a, 3'b011} ^ 64'h5A5A_0F0F_1234_8765;
  endfunction

  // Randomized-run model state
  bit           m_own [$];
  logic [60:0]  f_addr_q [$];
  logic [60:0]  d_addr_q [$];
  logic [60:0]  mem_q [$];
  bit           m_last, m_lock, m_lock_own;

  initial begin
    // Directed vectors, applied from reset one per cycle
    tbl[0]  = '{1,'h10, 0,0,     1,0,64'h0,                   1,'h10, 1,0,0,0,0};
    tbl[1]  = '{0,0,    0,0,     1,0,64'h0,                   0,0,    1,0,0,0,1};
    tbl[2]  = '{0,0,    0,0,     1,1,64'hDEAD_BEEF_0000_0001, 0,0,    1,0,1,0,1};
    tbl[3]  = '{0,0,    1,'h20,  1,0,64'h0,                   1,'h20, 0,1,0,0,0};
    tbl[4]  = '{1,'h100,1,'h200, 1,1,64'hA1,                  1,'h100,1,0,0,1,1};
    tbl[5]  = '{1,'h101,1,'h200, 1,1,64'hA2,                  1,'h200,0,1,1,0,1};
    tbl[6]  = '{1,'h101,1,'h201, 1,1,64'hA3,                  1,'h101,1,0,0,1,1};
    tbl[7]  = '{1,'h102,1,'h201, 1,1,64'hA4,                  1,'h201,0,1,1,0,1};
    tbl[8]  = '{1,'h102,1,'h202, 1,1,64'hA5,                  1,'h102,1,0,0,1,1};
    tbl[9]  = '{1,'h103,1,'h202, 1,1,64'hA6,                  1,'h202,0,1,1,0,1};
    tbl[10] = '{0,0,    0,0,     1,1,64'hA7,                  0,0,    1,0,0,1,1};
    tbl[11] = '{1,'h300,1,'h400, 0,0,64'h0,                   1,'h300,0,0,0,0,0};
    tbl[12] = '{1,'h300,1,'h400, 0,0,64'h0,                   1,'h300,0,0,0,0,0};
    tbl[13] = '{1,'h300,1,'h400, 0,0,64'h0,                   1,'h300,0,0,0,0,0};
    tbl[14] = '{1,'h300,1,'h400, 1,0,64'h0,                   1,'h300,1,0,0,0,0};
    tbl[15] = '{1,'h301,1,'h400, 1,0,64'h0,                   1,'h400,0,1,0,0,1};
    tbl[16] = '{0,0,    0,0,     1,1,64'hB1,                  0,0,    1,0,1,0,2};
    tbl[17] = '{0,0,    0,0,     1,1,64'hB2,                  0,0,    1,0,0,1,1};
    tbl[18] = '{0,0,    0,0,     1,0,64'h0,                   0,0,    1,0,0,0,0};

    // Reset state, with requests present that must be masked
    rst_n = 1'b0;
    drive(1, 'h55, 1, 'h66, 1, 1, 64'h1234);
    #3;
    chk("rst_mvalid", mem_req_valid, 0);
    chk("rst_fready", f_req_ready, 0);
    chk("rst_frsp", f_rsp_valid, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_err", err_orphan, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].fv, tbl[i].fa, tbl[i].dv, tbl[i].da, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      #4;
      chk($sformatf("v%0d_mvalid", i), mem_req_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("v%0d_maddr", i), mem_req_addr, tbl[i].e_ma);
      chk($sformatf("v%0d_fready", i), f_req_ready, tbl[i].e_fr);
      chk($sformatf("v%0d_dready", i), d_req_ready, tbl[i].e_dr);
      chk($sformatf("v%0d_frsp", i), f_rsp_valid, tbl[i].e_fv);
      chk($sformatf("v%0d_drsp", i), d_rsp_valid, tbl[i].e_dv);
      chk($sformatf("v%0d_fdata", i), f_rsp_data, tbl[i].rd);
      chk($sformatf("v%0d_ddata", i), d_rsp_data, tbl[i].rd);
      chk($sformatf("v%0d_out", i), outstanding, tbl[i].e_out);
      step();
    end

    // Fill to MAX_OUT (write pointer wraps), stall, pop, resume
    for (int i = 0; i < 4; i++) begin
      drive(1, 61'h500 + 61'(i), 0, 0, 1, 0, 0);
      #4;
      chk("full_fill_mvalid", mem_req_valid, 1);
      chk("full_fill_out", outstanding, i);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 'h504, 0, 0, 1, 0, 0);
      #4;
      chk("full_stall_mvalid", mem_req_valid, 0);
      chk("full_stall_fready", f_req_ready, 0);
      chk("full_stall_out", outstanding, 4);
      step();
    end
    drive(1, 'h504, 0, 0, 1, 1, 64'hC0);
    #4;
    chk("full_pop_frsp", f_rsp_valid, 1);
    chk("full_pop_mvalid", mem_req_valid, 0);
    chk("full_pop_out", outstanding, 4);
    step();
    drive(1, 'h504, 0, 0, 1, 0, 0);
    #4;
    chk("full_resume_mvalid", mem_req_valid, 1);
    chk("full_resume_addr", mem_req_addr, 'h504);
    chk("full_resume_fready", f_req_ready, 1);
    chk("full_resume_out", outstanding, 3);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 1, 64'hC1 + 64'(i));
      #4;
      chk("drain_frsp", f_rsp_valid, 1);
      chk("drain_drsp", d_rsp_valid, 0);
      chk("drain_out", outstanding, 4 - i);
      step();
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    #4;
    chk("drain_empty_out", outstanding, 0);
    step();

    // Orphan response
    drive(0, 0, 0, 0, 1, 1, 64'hEE);
    #4;
    chk("orphan_frsp", f_rsp_valid, 0);
    chk("orphan_drsp", d_rsp_valid, 0);
    chk("orphan_err_same_cycle", err_orphan, 0);
    chk("orphan_out", outstanding, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      #4;
      chk("orphan_err_sticky", err_orphan, 1);
      step();
    end

    // Reset with two requests outstanding
    drive(1, 'h600, 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 1, 'h700, 1, 0, 0);
    step();
    drive(1, 'h800, 1, 'h900, 1, 1, 64'hFF);
    #1;
    chk("pre_rst_out", outstanding, 2);
    rst_n = 1'b0;
    #1;
    chk("in_rst_mvalid", mem_req_valid, 0);
    chk("in_rst_maddr", mem_req_addr, 0);
    chk("in_rst_fready", f_req_ready, 0);
    chk("in_rst_dready", d_req_ready, 0);
    chk("in_rst_frsp", f_rsp_valid, 0);
    chk("in_rst_drsp", d_rsp_valid, 0);
    chk("in_rst_fdata", f_rsp_data, 0);
    chk("in_rst_out", outstanding, 0);
    chk("in_rst_err", err_orphan, 0);
    step();
    rst_n = 1'b1;
    drive(1, 'h800, 1, 'h900, 1, 0, 0);
    #4;
    chk("post_rst_out", outstanding, 0);
    chk("post_rst_tie_addr", mem_req_addr, 'h800);
    chk("post_rst_tie_fready", f_req_ready, 1);
    chk("post_rst_tie_dready", d_req_ready, 0);
    step();

    // Randomized run against the queue model
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    m_last = 1'b1; m_lock = 1'b0; m_lock_own = 1'b0;
    begin
      bit fpend, dpend, rdy, rv, can, sel, selv, e_mv, hs;
      logic [60:0] fa, da, ma;
      logic [63:0] rd;
      fpend = 0; dpend = 0; fa = 0; da = 0;
      for (int c = 0; c < 1500; c++) begin
        if (!fpend && $urandom_range(0, 2) != 0) begin fpend = 1; fa = 61'({$urandom(), $urandom()}); end
        if (!dpend && $urandom_range(0, 2) != 0) begin dpend = 1; da = 61'({$urandom(), $urandom()}); end
        rdy = ($urandom_range(0, 3) != 0);
        rv  = (mem_q.size() > 0) && ($urandom_range(0, 2) == 0);
        rd  = rv ? dfn(mem_q[0]) : {$urandom(), $urandom()};
        drive(fpend, fa, dpend, da, rdy, rv, rd);
        #4;
        can  = (m_own.size() < TMO);
        if (m_lock) sel = m_lock_own;
        else if (fpend && dpend) sel = !m_last;
        else sel = dpend;
        selv = sel ? dpend : fpend;
        e_mv = can && selv;
        ma   = sel ? da : fa;
        chk("rnd_mvalid", mem_req_valid, e_mv);
        if (e_mv) chk("rnd_maddr", mem_req_addr, ma);
        chk("rnd_fready", f_req_ready, !sel && rdy && can);
        chk("rnd_dready", d_req_ready, sel && rdy && can);
        chk("rnd_frsp", f_rsp_valid, rv && m_own.size() > 0 && m_own[0] == 0);
        chk("rnd_drsp", d_rsp_valid, rv && m_own.size() > 0 && m_own[0] == 1);
        chk("rnd_out", outstanding, m_own.size());
        chk("rnd_err", err_orphan, 0);
        if (f_rsp_valid && f_addr_q.size() > 0) chk("rnd_fdata", f_rsp_data, dfn(f_addr_q[0]));
        if (d_rsp_valid && d_addr_q.size() > 0) chk("rnd_ddata", d_rsp_data, dfn(d_addr_q[0]));
        hs = e_mv && rdy;
        if (rv && m_own.size() > 0) begin
          if (m_own.pop_front() == 0) void'(f_addr_q.pop_front());
          else void'(d_addr_q.pop_front());
          void'(mem_q.pop_front());
        end
        if (hs) begin
          m_own.push_back(sel);
          if (sel) d_addr_q.push_back(ma); else f_addr_q.push_back(ma);
          mem_q.push_back(ma);
          m_last = sel;
          m_lock = 0;
          if (sel) dpend = 0; else fpend = 0;
        end else if (e_mv) begin
          m_lock = 1;
          m_lock_own = sel;
        end
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares a single memory read port between instruction fetch and data load (`ld`/`ldu`), so the core can run on a one-port memory. Requests are arbitrated round-robin and issued to memory. The requester of each outstanding request is recorded in order, and every memory response is steered back to the requester that issued it. The block sits between the core's fetch/load address logic and `mem`.

## Interface
- `AW`, 61: doubleword address width, bit order [0:AW-1].
- `DW`, 64: data width, bit order [0:DW-1].
- `MAX_OUT`, 4: maximum outstanding memory requests; power of 2, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `f_req_valid`  in  1  fetch request.
- `f_req_addr`  in  AW  fetch doubleword address.
- `f_req_ready`  out  1  fetch request accepted this cycle.
- `f_rsp_valid`  out  1  fetch data valid.
- `f_rsp_data`  out  DW  fetch data.
- `d_req_valid`, `d_req_addr`, `d_req_ready`, `d_rsp_valid`, `d_rsp_data`: same widths and meanings, for the load requester.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_addr`  out  AW  address to memory.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_rsp_valid`  in  1  memory returns data, in request order.
- `mem_rsp_data`  in  DW  returned data.
- `outstanding`  out  $clog2(MAX_OUT)+1  count of issued, unanswered requests.
- `err_orphan`  out  1  sticky: a response arrived with nothing outstanding.

## Operation
- Handshake:
  - A request transfers when valid && ready.
  - Requesters hold valid and address stable until ready.
  - Responses have no backpressure; requesters must take `*_rsp_valid` data in the same cycle.
- Issue condition: `can_issue = (outstanding < MAX_OUT)`, using the registered count only.
  - No push when full, even if a pop happens in the same cycle.
- Arbitration, state `last_grant` ∈ {F, D}:
  - Only one requester valid: that requester is selected.
  - Both valid: the requester that is not `last_grant` is selected.
  - `last_grant` updates only on a memory handshake.
- Lock, state `lock_valid` plus `lock_owner`:
  - If `mem_req_valid && !mem_req_ready`, the selected owner is latched.
  - The next cycle forces the same owner, so address and owner stay stable until accepted.
  - The lock clears on handshake.
- Outputs:
  - `mem_req_valid = can_issue && (selected requester valid)`.
  - `mem_req_addr` is the selected requester's address.
  - The selected requester's ready is `mem_req_ready && can_issue`; the other requester's ready is 0.
  - `mem_req_valid` never depends on `mem_req_ready`.
- Owner FIFO, depth MAX_OUT, 1-bit entries:
  - Push the owner on memory handshake.
  - Pop on `mem_rsp_valid` when not empty.
  - Push and pop in the same cycle are both allowed; the count is unchanged.
- Response steering:
  - Head owner F gives `f_rsp_valid = mem_rsp_valid`; head owner D gives `d_rsp_valid = mem_rsp_valid`.
  - Both rsp data outputs carry `mem_rsp_data` unconditionally.
- Orphan response: `mem_rsp_valid` with the FIFO empty gives both rsp_valid 0, no pop, and `err_orphan` set to 1 until reset.
- Reset (async, any time):
  - FIFO emptied, `outstanding` = 0, `last_grant` = D so fetch wins the first tie, lock cleared, `err_orphan` = 0.
  - All outputs 0 while `rst_n` is low.
  - Responses to pre-reset requests count as orphans, so memory must be reset alongside the arbiter.

## Timing
- Request path is combinational: requester valid to `mem_req_valid` in the same cycle.
- Response path is combinational: `mem_rsp_valid` to `*_rsp_valid` in the same cycle.
- Total latency is the memory latency plus 0 cycles.
- Throughput is one request per cycle while not full; a full FIFO stalls issue until the cycle after a pop.
- `outstanding` and `err_orphan` are registered and update on the edge after the event.

## Structure
- Package `ppc_mem_pkg` holds `AW`, `DW`, typedef `owner_t` with `OWN_F`=0 and `OWN_D`=1, and the FIFO depth default.
- Sub-module `owner_fifo`:
  - Parameterised depth; push/pop/head/count/empty/full.
  - Read and write pointers of $clog2(depth) bits that wrap naturally.
  - A separate count register.
- Arbitration, lock and steering logic live in the top module.

## Test plan
- F only, addr 0x10, `mem_req_ready`=1, memory returns 0xDEAD_BEEF_0000_0001 two cycles later → `mem_req_addr` 0x10 in cycle 0; `f_rsp_valid` with that data in cycle 2; `d_rsp_valid` stays 0.
- F and D both valid every cycle for 6 cycles, ready=1, memory latency 1 → issue order F,D,F,D,F,D; responses steered alternately, each to the correct port.
- `mem_req_ready`=0 for 3 cycles while both requesters are valid → owner and address are held constant; handshake on cycle 3; `last_grant` updates only then.
- `MAX_OUT`=4, memory withholds responses → 4 issues, then `mem_req_valid`=0 and `outstanding`=4; one response → issue resumes the next cycle, including through a full-FIFO pointer wrap.
- `mem_rsp_valid` pulse with FIFO empty → no rsp_valid on either port; `err_orphan`=1 and held.
- Assert `rst_n`=0 with 2 requests outstanding → all outputs 0 immediately; after release `outstanding`=0 and a tie grants F first.
